// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
// Shadow entries carry a fixed-width dst; narrower AW values are zero-extended.
package hazard_pkg;

    localparam int unsigned DEF_AW = 5;
    localparam int unsigned MAX_AW = 8;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef struct packed {
        logic              valid;
        logic              regwr;
        logic              is_load;
        logic [MAX_AW-1:0] dst;
    } shadow_entry_t;

    // An entry can only be a hazard source if it really writes a non-zero register.
    function automatic logic writes_reg(shadow_entry_t e);
        return e.valid && e.regwr && (e.dst != '0);
    endfunction

endpackage

// File: rtl/haz_fwd_cmp.sv
// Per-operand forwarding comparator: picks MEM over WB over the register file.
module haz_fwd_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic              used,
    input  logic [AW-1:0]     src,
    input  logic              mem_ok,
    input  logic [MAX_AW-1:0] mem_dst,
    input  logic              wb_ok,
    input  logic [MAX_AW-1:0] wb_dst,
    output logic [1:0]        sel
);

    logic [MAX_AW-1:0] src_x;

    assign src_x = MAX_AW'(src);

    always_comb begin
        sel = FWD_RF;
        if (used && mem_ok && (mem_dst == src_x)) begin
            sel = FWD_MEM;
        end else if (used && wb_ok && (wb_dst == src_x)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline (shadow EX/MEM/WB).
// Optional perf counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic [AW-1:0]         id_dst,
    input  logic                  id_regwr,
    input  logic                  id_is_load,
    input  logic                  redirect,
    input  logic                  mem_wait,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  bubble_w,
    output logic [2*NUM_SRC-1:0]  fwd_sel
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    shadow_entry_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_entry;
    logic [NUM_SRC*AW-1:0]     ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;
    logic                      lu_hit, load_use;

    always_comb begin
        id_entry.valid   = id_valid;
        id_entry.regwr   = id_regwr;
        id_entry.is_load = id_is_load;
        id_entry.dst     = MAX_AW'(id_dst);
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && (MAX_AW'(id_src[k*AW +: AW]) == ex_q.dst)) begin
                lu_hit = 1'b1;
            end
        end
    end

    assign load_use = id_valid && writes_reg(ex_q) && ex_q.is_load && lu_hit;

    // Gated by rst_n so the controls read 0 while reset is held, whatever the inputs.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        bubble_w = 1'b0;
        if (!rst_n) begin
            stall_f = 1'b0;
        end else if (mem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        ex_d      = ex_q;
        ex_src_d  = ex_src_q;
        ex_used_d = ex_used_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        if (mem_wait) begin
            wb_d = '0;
        end else if (redirect) begin
            ex_d      = '0;
            ex_src_d  = '0;
            ex_used_d = '0;
            mem_d     = '0;
            wb_d      = mem_q;
        end else if (load_use) begin
            ex_d      = '0;
            ex_src_d  = '0;
            ex_used_d = '0;
            mem_d     = ex_q;
            wb_d      = mem_q;
        end else begin
            ex_d      = id_entry;
            ex_src_d  = id_src;
            ex_used_d = id_src_used & {NUM_SRC{id_valid}};
            mem_d     = ex_q;
            wb_d      = mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_src_q  <= '0;
            ex_used_q <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
        end else begin
            ex_q      <= ex_d;
            ex_src_q  <= ex_src_d;
            ex_used_q <= ex_used_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
        end
    end

    // A load in MEM has no data yet, so it never qualifies as a MEM forward.
    logic mem_ok, wb_ok;

    assign mem_ok = writes_reg(mem_q) && !mem_q.is_load;
    assign wb_ok  = writes_reg(wb_q);

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        haz_fwd_cmp #(
            .AW (AW)
        ) u_cmp (
            .used    (ex_used_q[k]),
            .src     (ex_src_q[k*AW +: AW]),
            .mem_ok  (mem_ok),
            .mem_dst (mem_q.dst),
            .wb_ok   (wb_ok),
            .wb_dst  (wb_q.dst),
            .sel     (fwd_sel[2*k +: 2])
        );
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_f) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (redirect && !mem_wait) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized and directed bench for pipe_hazard_unit against an instruction-level model.
module tb_pipe_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int CW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0]  id_src_used;
    logic [AW-1:0]  id_dst;
    logic           id_regwr, id_is_load, redirect, mem_wait;
    logic           stall_f, stall_d, flush_d, flush_e, flush_m, stall_e, stall_m, bubble_w;
    logic [2*NS-1:0] fwd_sel;
    logic [CW-1:0]  perf_stall_cnt, perf_flush_cnt;
    logic [7:0]     ctl;

    always #5 clk = ~clk;

    assign ctl = {stall_f, stall_d, flush_d, flush_e, flush_m, stall_e, stall_m, bubble_w};

    pipe_hazard_unit #(
        .AW      (AW),
        .NUM_SRC (NS),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dst      (id_dst),
        .id_regwr    (id_regwr),
        .id_is_load  (id_is_load),
        .redirect    (redirect),
        .mem_wait    (mem_wait),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .bubble_w    (bubble_w),
        .fwd_sel     (fwd_sel)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

`ifndef HAZ_PERF_EN
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

    // In-flight instruction as the model sees it; slot 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit       wr;
        bit       ld;
        int       dst;
        int       src0;
        int       src1;
        bit [1:0] used;
    } ins_t;

    ins_t        pipe [3];
    ins_t        nop_ins;
    int          n_checks = 0;
    int          n_errors = 0;
    bit [31:0]   m_stall = 0;
    bit [31:0]   m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writer(ins_t e);
        return e.v && e.wr && (e.dst != 0);
    endfunction

    function automatic int src_of(ins_t e, int k);
        return (k == 0) ? e.src0 : e.src1;
    endfunction

    function automatic ins_t id_ins();
        ins_t e;
        e.v    = id_valid;
        e.wr   = id_regwr;
        e.ld   = id_is_load;
        e.dst  = int'(id_dst);
        e.src0 = int'(id_src[AW-1:0]);
        e.src1 = int'(id_src[2*AW-1:AW]);
        e.used = id_valid ? id_src_used : 2'b00;
        return e;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = nop_ins;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] u,
                          input int d, input bit wr, input bit ld);
        id_valid    = v;
        id_src      = {AW'(s1), AW'(s0)};
        id_src_used = u;
        id_dst      = AW'(d);
        id_regwr    = wr;
        id_is_load  = ld;
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic tick();
        ins_t       cur;
        bit         lu;
        logic [7:0] exp_ctl;
        logic [3:0] exp_fwd;
        int         r;
        @(negedge clk);
        cur = id_ins();
        lu = 1'b0;
        if (id_valid && writer(pipe[0]) && pipe[0].ld) begin
            for (int k = 0; k < NS; k++)
                if (cur.used[k] && src_of(cur, k) == pipe[0].dst) lu = 1'b1;
        end
        if (mem_wait)      exp_ctl = 8'b1100_0111;
        else if (redirect) exp_ctl = 8'b0011_1000;
        else if (lu)       exp_ctl = 8'b1101_0000;
        else               exp_ctl = 8'b0000_0000;
        exp_fwd = '0;
        for (int k = 0; k < NS; k++) begin
            r = src_of(pipe[0], k);
            if (pipe[0].used[k]) begin
                if (writer(pipe[1]) && !pipe[1].ld && pipe[1].dst == r) exp_fwd[2*k +: 2] = 2'd2;
                else if (writer(pipe[2]) && pipe[2].dst == r)          exp_fwd[2*k +: 2] = 2'd1;
            end
        end
        check("ctl", 32'(ctl), 32'(exp_ctl));
        check("fwd_sel", 32'(fwd_sel), 32'(exp_fwd));
`ifdef HAZ_PERF_EN
        check("perf_stall", perf_stall_cnt, m_stall);
        check("perf_flush", perf_flush_cnt, m_flush);
        if (exp_ctl[7]) m_stall++;
        if (redirect && !mem_wait) m_flush++;
`endif
        if (mem_wait) begin
            pipe[2] = nop_ins;
        end else if (redirect) begin
            pipe[2] = pipe[1];
            pipe[1] = nop_ins;
            pipe[0] = nop_ins;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = lu ? nop_ins : cur;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_ctl", 32'(ctl), 32'h0);
        check("rst_fwd", 32'(fwd_sel), 32'h0);
`ifdef HAZ_PERF_EN
        check("rst_perf_stall", perf_stall_cnt, 32'h0);
        check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        redirect = 1'b0;
        mem_wait = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        mem_wait = 1'b0;

        // Load-use: lw r2 then a reader of r2.
        set_id(1'b1, 0, 0, 2'b00, 2, 1'b1, 1'b1); tick();
        set_id(1'b1, 2, 0, 2'b01, 4, 1'b1, 1'b0);
        #2; check("lu_stall", 32'({stall_f, stall_d, flush_e, stall_e}), 32'b1110);
        tick();
        #2; check("lu_once", 32'(stall_f), 32'h0);
        tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2; check("lu_fwd_wb", 32'(fwd_sel[1:0]), 32'h1);
        tick();

        // ALU back-to-back, one-gap and r0 forwarding.
        set_id(1'b1, 0, 0, 2'b00, 3, 1'b1, 1'b0); tick();
        set_id(1'b1, 3, 0, 2'b01, 6, 1'b1, 1'b0); tick();
        set_id(1'b1, 3, 0, 2'b01, 7, 1'b1, 1'b0);
        #2; check("fwd_mem", 32'(fwd_sel[1:0]), 32'h2);
        tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2; check("fwd_wb_gap", 32'(fwd_sel[1:0]), 32'h1);
        tick();
        set_id(1'b1, 0, 0, 2'b00, 0, 1'b1, 1'b0); tick();
        set_id(1'b1, 0, 0, 2'b01, 8, 1'b1, 1'b0); tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2; check("fwd_r0", 32'(fwd_sel[1:0]), 32'h0);
        tick();

        // MEM and WB both write r5; both operands read r5.
        set_id(1'b1, 0, 0, 2'b00, 5, 1'b1, 1'b0); tick();
        set_id(1'b1, 0, 0, 2'b00, 5, 1'b1, 1'b0); tick();
        set_id(1'b1, 5, 5, 2'b11, 9, 1'b1, 1'b0); tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2; check("fwd_mem_beats_wb", 32'(fwd_sel), 32'b1010);
        tick();

        // Redirect together with a load-use condition.
        set_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1); tick();
        set_id(1'b1, 7, 0, 2'b01, 10, 1'b1, 1'b0);
        redirect = 1'b1;
        #2; check("redir_prio", 32'({flush_d, flush_e, flush_m, stall_f, stall_d}), 32'b11100);
        tick();
        redirect = 1'b0;
        set_id(1'b1, 7, 7, 2'b11, 11, 1'b1, 1'b0);
        #2; check("redir_ex_gone", 32'(stall_f), 32'h0);
        tick();

        // mem_wait for 3 cycles with a load sitting in MEM.
        set_id(1'b1, 0, 0, 2'b00, 9, 1'b1, 1'b1); tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0); tick();
        set_id(1'b1, 9, 0, 2'b01, 12, 1'b1, 1'b0);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2; check("wait_ctl", 32'(ctl), 32'b1100_0111);
            tick();
        end
        mem_wait = 1'b0;
        #2; check("wait_release", 32'(ctl), 32'h0);
        tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2; check("wait_load_wb", 32'(fwd_sel[1:0]), 32'h1);
        tick();

        // Randomized traffic with a small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            set_id(1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0));
            redirect = ($urandom_range(0, 7) == 0);
            mem_wait = ($urandom_range(0, 5) == 0);
            tick();
        end

`ifdef HAZ_PERF_EN
        redirect = 1'b0;
        mem_wait = 1'b0;
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        do_reset();
        set_id(1'b1, 0, 0, 2'b00, 2, 1'b1, 1'b1); tick();
        set_id(1'b1, 2, 0, 2'b01, 4, 1'b1, 1'b0); tick();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mem_wait = 1'b0;
        redirect = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        redirect = 1'b0;
        #2;
        check("perf_stall_4", perf_stall_cnt, 32'd4);
        check("perf_flush_2", perf_flush_cnt, 32'd2);
`endif

        // Asynchronous reset mid-activity with hazard inputs still driven.
        set_id(1'b1, 1, 2, 2'b11, 3, 1'b1, 1'b1);
        mem_wait = 1'b1;
        redirect = 1'b1;
        do_reset();
        mem_wait = 1'b0;
        redirect = 1'b0;
        set_id(1'b1, 3, 3, 2'b11, 4, 1'b1, 1'b0);
        #2; check("post_rst_quiet", 32'(ctl), 32'h0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
